// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command sequencer in front of TotalALU.
//   Accepts one {ctrl, A, B} command at a time over cmd_valid/cmd_ready and
//   drives TotalALU's Signal/dataA/dataB. A MULTU is held for MUL_CYCLES
//   cycles, followed by MUL_GAP NOP cycles. MFHI and then MFLO are issued
//   automatically to read the product back. Each ALU result word is
//   returned over res_valid/res_ready.
// Optional feature: `define ALU_ISSUE_OPCHK_EN rejects unknown opcodes.
//   A rejected op drives NOP and answers with res_err=1, res_data=0.
// Ports:
//   clk, reset                      rising-edge clock; sync active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in idle)
//   cmd_ctrl, cmd_a, cmd_b          opcode and operands
//   alu_signal, alu_a, alu_b        to TotalALU Signal/dataA/dataB
//   alu_out                         from TotalALU Output
//   res_valid/res_ready             result handshake
//   res_data, res_hi, res_last      result word, HI-half flag, final-word flag
//   res_err                         opcode rejected (0 unless OPCHK enabled)
module alu_issue_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_CYCLES = 33,
  parameter int unsigned MUL_GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_ctrl,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [5:0]        alu_signal,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_hi,
  output logic              res_last,
  output logic              res_err
);

  localparam logic [5:0] OpNop   = 6'd0;
  localparam logic [5:0] OpMultu = 6'd25;
  localparam logic [5:0] OpMfhi  = 6'd16;
  localparam logic [5:0] OpMflo  = 6'd18;

  // The counter is reloaded on every state entry, so it never wraps.
  localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] GapLoad = 6'(MUL_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StIssue, StMulWait, StGap, StRdHi, StRespHi, StRdLo, StResp
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              bad_q, bad_d;
  logic              cmd_bad;

`ifdef ALU_ISSUE_OPCHK_EN
  always_comb begin
    unique case (cmd_ctrl)
      6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25: cmd_bad = 1'b0;
      default:                                        cmd_bad = 1'b1;
    endcase
  end
`else
  assign cmd_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    err_d      = err_q;
    bad_d      = bad_q;
    alu_signal = OpNop;
    unique case (state_q)
      StIdle: begin
        // cmd_ready is high in idle, so valid alone means accept.
        if (cmd_valid) begin
          ctrl_d = cmd_ctrl;
          a_d    = cmd_a;
          b_d    = cmd_b;
          bad_d  = cmd_bad;
          if (cmd_ctrl == OpMultu) begin
            state_d = StMulWait;
            cnt_d   = MulLoad;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        alu_signal = bad_q ? OpNop : ctrl_q;
        data_d     = bad_q ? '0 : alu_out;
        err_d      = bad_q;
        state_d    = StResp;
      end
      StMulWait: begin
        alu_signal = OpMultu;
        if (cnt_q == 6'd0) begin
          if (MUL_GAP == 0) begin
            state_d = StRdHi;
          end else begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StGap: begin
        if (cnt_q == 6'd0) state_d = StRdHi;
        else               cnt_d   = cnt_q - 6'd1;
      end
      StRdHi: begin
        alu_signal = OpMfhi;
        data_d     = alu_out;
        err_d      = 1'b0;
        state_d    = StRespHi;
      end
      StRespHi: begin
        if (res_ready) state_d = StRdLo;
      end
      StRdLo: begin
        alu_signal = OpMflo;
        data_d     = alu_out;
        err_d      = 1'b0;
        state_d    = StResp;
      end
      StResp: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  // Operands come straight from the latched command, so they hold their
  // last value whenever the ALU is idle.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign cmd_ready = (state_q == StIdle);
  assign res_valid = (state_q == StResp) || (state_q == StRespHi);
  assign res_hi    = (state_q == StRespHi);
  assign res_last  = (state_q == StResp);
  assign res_data  = data_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_ctrl;
  logic [31:0] cmd_a, cmd_b;
  logic [5:0]  alu_signal;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_hi, res_last, res_err;

  int checks   = 0;
  int failures = 0;
  int mul_cnt  = 0;
  int nz_cnt   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(32), .MUL_CYCLES(33), .MUL_GAP(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ctrl   (cmd_ctrl),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_signal (alu_signal),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_hi     (res_hi),
    .res_last   (res_last),
    .res_err    (res_err)
  );

  // Behavioural stand-in for TotalALU: combinational ops, HI/LO product regs.
  logic [31:0] hi_q, lo_q;
  always @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (alu_signal == 6'd25) begin
      {hi_q, lo_q} <= 64'(alu_a) * 64'(alu_b);
    end
  end

  always_comb begin
    alu_out = '0;
    case (alu_signal)
      6'd36: alu_out = alu_a & alu_b;
      6'd37: alu_out = alu_a | alu_b;
      6'd32: alu_out = alu_a + alu_b;
      6'd34: alu_out = alu_a - alu_b;
      6'd42: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'd2:  alu_out = alu_a >> alu_b[4:0];
      6'd16: alu_out = hi_q;
      6'd18: alu_out = lo_q;
      default: alu_out = '0;
    endcase
  end

  always @(negedge clk) begin
    if (alu_signal == 6'd25) mul_cnt++;
    if (alu_signal != 6'd0)  nz_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_ctrl  = c;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Cycles from the accept edge until res_valid is seen (bounded).
  task automatic wait_res(output int lat);
    lat = 1;
    @(negedge clk);
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic single(input string tag, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    send(c, a, b);
    wait_res(lat);
    check({tag, "_lat"}, lat, 32'd2);
    check({tag, "_data"}, res_data, exp);
    check({tag, "_last"}, {31'd0, res_last}, 32'd1);
    check({tag, "_hi"}, {31'd0, res_hi}, 32'd0);
    ack();
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ctrl  = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_flags", {29'd0, res_hi, res_last, res_err}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_alu_signal", {26'd0, alu_signal}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);

    // Single-cycle ops
    single("add", 6'd32, 32'd5, 32'd7, 32'd12);
    single("sub", 6'd34, 32'd3, 32'd5, 32'hFFFFFFFE);
    single("slt", 6'd42, 32'd3, 32'd5, 32'd1);
    single("srl", 6'd2, 32'h80000000, 32'd4, 32'h08000000);
    single("and", 6'd36, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    check("idle_signal_nop", {26'd0, alu_signal}, 32'd0);
    check("idle_a_held", alu_a, 32'hF0F0_1234);

    // MULTU with auto MFHI/MFLO readback
    mul_cnt = 0;
    send(6'd25, 32'hFFFFFFFF, 32'd2);
    wait_res(lat);
    check("mul_hi_lat", lat, 32'd37);
    check("mul_hi_data", res_data, 32'd1);
    check("mul_hi_flag", {31'd0, res_hi}, 32'd1);
    check("mul_hi_last", {31'd0, res_last}, 32'd0);
    check("mul_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    ack();
    wait_res(lat);
    check("mul_lo_lat", lat, 32'd2);
    check("mul_lo_data", res_data, 32'hFFFFFFFE);
    check("mul_lo_flag", {31'd0, res_hi}, 32'd0);
    check("mul_lo_last", {31'd0, res_last}, 32'd1);
    ack();
    check("mul_signal_cycles", mul_cnt, 32'd33);

    // Backpressure: result held stable for 3 cycles
    send(6'd32, 32'd1, 32'd1);
    wait_res(lat);
    check("bp_lat", lat, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_data", res_data, 32'd2);
      check("bp_last", {31'd0, res_last}, 32'd1);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    ack();
    @(negedge clk);
    check("bp_valid_drop", {31'd0, res_valid}, 32'd0);
    check("bp_cmd_ready_up", {31'd0, cmd_ready}, 32'd1);

    // Reset pulse in the middle of a MULTU
    send(6'd25, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("mrst_signal", {26'd0, alu_signal}, 32'd0);
    check("mrst_alu_a", alu_a, 32'd0);
    single("post_rst_add", 6'd32, 32'd2, 32'd3, 32'd5);

    // Unknown opcode
    nz_cnt = 0;
    send(6'd7, 32'd11, 32'd22);
    wait_res(lat);
    check("bad_lat", lat, 32'd2);
    check("bad_last", {31'd0, res_last}, 32'd1);
`ifdef ALU_ISSUE_OPCHK_EN
    check("bad_err", {31'd0, res_err}, 32'd1);
    check("bad_data", res_data, 32'd0);
    check("bad_signal_nop", nz_cnt, 32'd0);
`else
    check("bad_err", {31'd0, res_err}, 32'd0);
    check("bad_signal_fwd", nz_cnt, 32'd1);
`endif
    ack();
    single("after_bad_or", 6'd37, 32'hA0, 32'h0B, 32'hAB);
    check("after_bad_err", {31'd0, res_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
